// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared defaults and helpers for the parameterised register file.
//   DEFAULT_WIDTH : default data width of one register, in bits
//   DEFAULT_DEPTH : default number of registers
//   addr_width()  : address bits needed to select one of 'depth' registers
// -----------------------------------------------------------------------------
package regfile_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_DEPTH = 32;

  // ceil(log2(depth)), never less than one bit so that a 2-entry file
  // still has a real address port.
  function automatic int addr_width(input int depth);
    int w;
    w = 1;
    while ((1 << w) < depth) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage : regfile_pkg

// File: rtl/dffe_reg.sv
// -----------------------------------------------------------------------------
// dffe_reg
// One storage register of the file: WIDTH flops with a load enable and an
// asynchronous active-low clear.
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low clear
//   en      : load d on the next rising edge
//   d       : data to load
//   q       : stored value
// -----------------------------------------------------------------------------
module dffe_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  always_comb begin
    // NOTE: every path assigns data_d, so no latch is inferred.
    data_d = data_q;
    if (en) begin
      data_d = d;
    end
  end

  // NOTE: the file is built from flops rather than a RAM macro, which is what
  // allows every entry to be cleared asynchronously by reset_n.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: non-blocking assignment keeps all state updates in this edge
      // ordered after every read of the old values.
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule : dffe_reg

// File: rtl/param_regfile.sv
// -----------------------------------------------------------------------------
// param_regfile
// Parameterised register file: one write port, two independent combinational
// read ports, optional hard-wired zero register, asynchronous clear.
//
// Parameters
//   WIDTH    : bits per register
//   DEPTH    : number of registers (2..256); need not be a power of two
//   ZERO_REG : 1 -> register 0 always reads 0 and ignores writes
//
// Ports
//   clk      : rising-edge clock for all writes
//   reset_n  : asynchronous active-low clear of every register
//   we       : write enable, sampled on the rising edge of clk
//   waddr    : write address
//   wdata    : write data
//   raddr_a  : read address, port A
//   rdata_a  : read data, port A
//   raddr_b  : read address, port B
//   rdata_b  : read data, port B
//
// Build option
//   REGFILE_BYPASS_EN : when defined, a write in progress is forwarded to any
//   read port addressing the same writable register before the clock edge.
//   When undefined, reads show the stored value until the edge.
// -----------------------------------------------------------------------------
module param_regfile
  import regfile_pkg::*;
#(
  parameter  int WIDTH    = DEFAULT_WIDTH,
  parameter  int DEPTH    = DEFAULT_DEPTH,
  parameter  int ZERO_REG = 1,
  localparam int ADDR_W   = addr_width(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [WIDTH-1:0]  rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [WIDTH-1:0]  rdata_b
);

  logic [WIDTH-1:0] reg_q [DEPTH];
  logic [DEPTH-1:0] wr_en;
  logic [WIDTH-1:0] stored_a;
  logic [WIDTH-1:0] stored_b;

  // ---------------------------------------------------------------------------
  // Storage and write decode. Only addresses 0..DEPTH-1 have a decoder term,
  // so writes beyond DEPTH match nothing and are dropped.
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < DEPTH; i++) begin : g_reg
    if ((ZERO_REG != 0) && (i == 0)) begin : g_zero
      assign wr_en[i] = 1'b0;
      assign reg_q[i] = '0;
    end else begin : g_ff
      assign wr_en[i] = we && (waddr == ADDR_W'(i));

      dffe_reg #(
        .WIDTH (WIDTH)
      ) u_reg (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (wr_en[i]),
        .d       (wdata),
        .q       (reg_q[i])
      );
    end
  end

  // ---------------------------------------------------------------------------
  // Read multiplexers. Addresses with no register fall through to zero.
  // ---------------------------------------------------------------------------
  always_comb begin
    stored_a = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (raddr_a == ADDR_W'(i)) begin
        stored_a = reg_q[i];
      end
    end
  end

  always_comb begin
    stored_b = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (raddr_b == ADDR_W'(i)) begin
        stored_b = reg_q[i];
      end
    end
  end

`ifdef REGFILE_BYPASS_EN
  // A write is forwardable only if it would actually land in a register:
  // wr_en already excludes the zero register and out-of-range addresses, so
  // an address match with any live write enable implies a writable target.
  logic wr_live;

  assign wr_live = reset_n && (|wr_en);
  assign rdata_a = (wr_live && (raddr_a == waddr)) ? wdata : stored_a;
  assign rdata_b = (wr_live && (raddr_b == waddr)) ? wdata : stored_b;
`else
  assign rdata_a = stored_a;
  assign rdata_b = stored_b;
`endif

endmodule : param_regfile

// File: tb/tb_param_regfile.sv
// -----------------------------------------------------------------------------
// tb_param_regfile
// Three register files share one stimulus stream:
//   u_def : WIDTH=32 DEPTH=32 ZERO_REG=1 (defaults)
//   u_nz  : WIDTH=32 DEPTH=8  ZERO_REG=0
//   u_odd : WIDTH=8  DEPTH=20 ZERO_REG=1 (non power-of-two depth)
// Each instance sees the low address/data bits it can hold. A plain array
// model per instance predicts every read.
// -----------------------------------------------------------------------------
module tb_param_regfile;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        we;
  logic [7:0]  waddr;
  logic [31:0] wdata;
  logic [7:0]  raddr_a;
  logic [7:0]  raddr_b;

  logic [31:0] rd_a_def, rd_b_def;
  logic [31:0] rd_a_nz,  rd_b_nz;
  logic [7:0]  rd_a_odd, rd_b_odd;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  param_regfile #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1)) u_def (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (we),
    .waddr   (waddr[4:0]),
    .wdata   (wdata),
    .raddr_a (raddr_a[4:0]),
    .rdata_a (rd_a_def),
    .raddr_b (raddr_b[4:0]),
    .rdata_b (rd_b_def)
  );

  param_regfile #(.WIDTH(32), .DEPTH(8), .ZERO_REG(0)) u_nz (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (we),
    .waddr   (waddr[2:0]),
    .wdata   (wdata),
    .raddr_a (raddr_a[2:0]),
    .rdata_a (rd_a_nz),
    .raddr_b (raddr_b[2:0]),
    .rdata_b (rd_b_nz)
  );

  param_regfile #(.WIDTH(8), .DEPTH(20), .ZERO_REG(1)) u_odd (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (we),
    .waddr   (waddr[4:0]),
    .wdata   (wdata[7:0]),
    .raddr_a (raddr_a[4:0]),
    .rdata_a (rd_a_odd),
    .raddr_b (raddr_b[4:0]),
    .rdata_b (rd_b_odd)
  );

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  localparam int          DEP  [3] = '{32, 8, 20};
  localparam int          AW   [3] = '{5, 3, 5};
  localparam int          ZR   [3] = '{1, 0, 1};
  localparam logic [31:0] MASK [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_00FF};

  logic [31:0] mem [3][32];

  function automatic int local_addr(input int k, input logic [7:0] a);
    return int'(a) % (1 << AW[k]);
  endfunction

  function automatic bit writable(input int k, input int a);
    return (a < DEP[k]) && !((ZR[k] == 1) && (a == 0));
  endfunction

  function automatic logic [31:0] exp_read(input int k, input logic [7:0] ra);
    int a;
    int wa;
    a  = local_addr(k, ra);
    wa = local_addr(k, waddr);
`ifdef REGFILE_BYPASS_EN
    if (we && reset_n && writable(k, wa) && (a == wa)) begin
      return wdata & MASK[k];
    end
`endif
    if (!writable(k, a)) begin
      return 32'h0;
    end
    return mem[k][a];
  endfunction

  function automatic logic [31:0] obs_a(input int k);
    case (k)
      0:       return rd_a_def;
      1:       return rd_a_nz;
      default: return {24'h0, rd_a_odd};
    endcase
  endfunction

  function automatic logic [31:0] obs_b(input int k);
    case (k)
      0:       return rd_b_def;
      1:       return rd_b_nz;
      default: return {24'h0, rd_b_odd};
    endcase
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 3; k++) begin
      for (int a = 0; a < 32; a++) begin
        mem[k][a] = 32'h0;
      end
    end
  endtask

  // Apply the pending write to the model, then let the DUT see the edge.
  task automatic tick();
    if (reset_n && we) begin
      for (int k = 0; k < 3; k++) begin
        int wa;
        wa = local_addr(k, waddr);
        if (writable(k, wa)) begin
          mem[k][wa] = wdata & MASK[k];
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reads(input string tag);
    logic [31:0] got;
    logic [31:0] want;
    for (int k = 0; k < 3; k++) begin
      got  = obs_a(k);
      want = exp_read(k, raddr_a);
      checks++;
      assert (got === want) else begin
        failures++;
        $error("FAIL %s inst%0d portA addr=%0d: got %h expected %h", tag, k, raddr_a, got, want);
      end
      got  = obs_b(k);
      want = exp_read(k, raddr_b);
      checks++;
      assert (got === want) else begin
        failures++;
        $error("FAIL %s inst%0d portB addr=%0d: got %h expected %h", tag, k, raddr_b, got, want);
      end
    end
  endtask

  task automatic check_addr(input string tag, input logic [7:0] a, input logic [7:0] b);
    raddr_a = a;
    raddr_b = b;
    #1;
    check_reads(tag);
  endtask

  task automatic write(input logic [7:0] a, input logic [31:0] d);
    we    = 1'b1;
    waddr = a;
    wdata = d;
    tick();
    we    = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Directed and random sequence
  // ---------------------------------------------------------------------------
  initial begin
    reset_n = 1'b0;
    we      = 1'b0;
    waddr   = 8'd0;
    wdata   = 32'h0;
    raddr_a = 8'd0;
    raddr_b = 8'd0;
    model_clear();

    // Reset state
    #2;
    check_addr("reset_state", 8'd1, 8'd7);
    check_addr("reset_state", 8'd19, 8'd31);

    // First write after deassertion lands on the first qualifying edge
    @(negedge clk);
    reset_n = 1'b1;
    we      = 1'b1;
    waddr   = 8'd9;
    wdata   = 32'h1122_3344;
    check_addr("first_write_pre", 8'd9, 8'd1);
    tick();
    we = 1'b0;
    check_addr("first_write_post", 8'd9, 8'd9);

    // Write/read on register 5, neighbours untouched
    write(8'd5, 32'hDEAD_BEEF);
    check_addr("wr5_same", 8'd5, 8'd5);
    check_addr("wr5_neigh", 8'd4, 8'd6);

    // Zero register
    write(8'd0, 32'h1234_5678);
    check_addr("zero_reg", 8'd0, 8'd0);

    // Bypass window: old value vs. forwarded write data before the edge
    write(8'd7, 32'h0BAD_F00D);
    we      = 1'b1;
    waddr   = 8'd7;
    wdata   = 32'hA5A5_A5A5;
    check_addr("bypass_pre", 8'd7, 8'd6);
    tick();
    we = 1'b0;
    check_addr("bypass_post", 8'd7, 8'd7);

    // Out-of-range write for the 20-deep instance
    write(8'd25, 32'h0000_003C);
    check_addr("range_25", 8'd25, 8'd25);
    for (int a = 0; a < 20; a++) begin
      check_addr("range_keep", 8'(a), 8'(19 - a));
    end

    // Fill with ones, then clear asynchronously mid-cycle
    for (int a = 0; a < 32; a++) begin
      write(8'(a), 32'hFFFF_FFFF);
    end
    check_addr("ones_loaded", 8'd3, 8'd31);
    @(negedge clk);
    reset_n = 1'b0;
    model_clear();
    check_addr("async_clear", 8'd3, 8'd31);
    for (int a = 0; a < 32; a++) begin
      check_addr("async_sweep", 8'(a), 8'(31 - a));
    end
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    check_addr("after_release", 8'd1, 8'd2);

    // Random traffic, reads checked before each edge
    for (int n = 0; n < 300; n++) begin
      we      = 1'($urandom_range(0, 1));
      waddr   = 8'($urandom_range(0, 31));
      wdata   = $urandom;
      raddr_a = ($urandom_range(0, 3) == 0) ? waddr : 8'($urandom_range(0, 31));
      raddr_b = ($urandom_range(0, 3) == 0) ? raddr_a : 8'($urandom_range(0, 31));
      #1;
      check_reads("random");
      tick();
    end
    we = 1'b0;

    // Reset colliding with a write edge: reset wins
    write(8'd3, 32'h7777_7777);
    check_addr("collide_pre", 8'd3, 8'd3);
    we    = 1'b1;
    waddr = 8'd3;
    wdata = 32'hCAFE_F00D;
    @(posedge clk);
    reset_n = 1'b0;
    model_clear();
    #1;
    we = 1'b0;
    check_addr("collide_rst", 8'd3, 8'd3);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    check_addr("collide_post", 8'd3, 8'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_param_regfile
